// File: rtl/ppg_moving_avg.sv
// Boxcar moving average over 2**LOG2_N samples for the red and IR PPG channels.
// One ring buffer holds both channels; running sums are updated once per sample edge.
module ppg_moving_avg #(
    parameter int DATA_W = 22,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              in_reset,
    input  logic              in_new_samples,
    input  logic [DATA_W-1:0] in_red,
    input  logic [DATA_W-1:0] in_ir,
    output logic [DATA_W-1:0] out_red_avg,
    output logic [DATA_W-1:0] out_ir_avg,
    output logic              out_valid,
    input  logic              in_ready,
    output logic              out_primed,
    output logic              out_overrun
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = DATA_W + LOG2_N;
    localparam logic [LOG2_N:0] FULL = {1'b1, {LOG2_N{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_UPDATE,
        S_PRESENT
    } state_t;

    state_t              state_q, state_d;
    logic                nsd_q;
    logic [DATA_W-1:0]   cap_red_q, cap_red_d;
    logic [DATA_W-1:0]   cap_ir_q, cap_ir_d;
    logic [LOG2_N-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LOG2_N:0]     fill_q, fill_d;
    logic [SW-1:0]       sum_red_q, sum_red_d;
    logic [SW-1:0]       sum_ir_q, sum_ir_d;
    logic [DATA_W-1:0]   red_avg_q, red_avg_d;
    logic [DATA_W-1:0]   ir_avg_q, ir_avg_d;
    logic                valid_q, valid_d;
    logic                primed_q, primed_d;
    logic                overrun_q, overrun_d;

    logic [2*DATA_W-1:0] mem [N];
    logic [2*DATA_W-1:0] ram_q;
    logic                ram_rd_en;
    logic                ram_wr_en;

    logic                new_edge;
    logic                window_full;
    logic [DATA_W-1:0]   old_red;
    logic [DATA_W-1:0]   old_ir;

    function automatic logic [SW-1:0] sext(input logic [DATA_W-1:0] x);
        return {{LOG2_N{x[DATA_W-1]}}, x};
    endfunction

    assign new_edge    = in_new_samples & ~nsd_q;
    assign window_full = (fill_q == FULL);
    // Until the window has filled once, slots read back stale data and must contribute zero.
    assign old_red     = window_full ? ram_q[2*DATA_W-1:DATA_W] : '0;
    assign old_ir      = window_full ? ram_q[DATA_W-1:0]        : '0;

    always_ff @(posedge clk) begin
        if (ram_wr_en) begin
            mem[wr_ptr_q] <= {cap_red_q, cap_ir_q};
        end
        if (ram_rd_en) begin
            ram_q <= mem[wr_ptr_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        cap_red_d = cap_red_q;
        cap_ir_d  = cap_ir_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        sum_red_d = sum_red_q;
        sum_ir_d  = sum_ir_q;
        red_avg_d = red_avg_q;
        ir_avg_d  = ir_avg_q;
        valid_d   = valid_q;
        primed_d  = primed_q;
        overrun_d = overrun_q;
        ram_rd_en = 1'b0;
        ram_wr_en = 1'b0;

        if (new_edge && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
        if (valid_q && in_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (new_edge) begin
                    cap_red_d = in_red;
                    cap_ir_d  = in_ir;
                    ram_rd_en = 1'b1;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                sum_red_d = sum_red_q + sext(cap_red_q) - sext(old_red);
                sum_ir_d  = sum_ir_q + sext(cap_ir_q) - sext(old_ir);
                ram_wr_en = ~in_reset;
                wr_ptr_d  = wr_ptr_q + LOG2_N'(1);
                if (!window_full) begin
                    fill_d = fill_q + (LOG2_N+1)'(1);
                end
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                // Dropping the low bits of a two's-complement sum is an arithmetic shift (floor).
                red_avg_d = sum_red_q[SW-1:LOG2_N];
                ir_avg_d  = sum_ir_q[SW-1:LOG2_N];
                if (window_full) begin
                    primed_d = 1'b1;
                    valid_d  = 1'b1;
                    if (valid_q && !in_ready) begin
                        overrun_d = 1'b1;
                    end
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_reset) begin
            state_q   <= S_IDLE;
            nsd_q     <= 1'b0;
            cap_red_q <= '0;
            cap_ir_q  <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            sum_red_q <= '0;
            sum_ir_q  <= '0;
            red_avg_q <= '0;
            ir_avg_q  <= '0;
            valid_q   <= 1'b0;
            primed_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nsd_q     <= in_new_samples;
            cap_red_q <= cap_red_d;
            cap_ir_q  <= cap_ir_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            sum_red_q <= sum_red_d;
            sum_ir_q  <= sum_ir_d;
            red_avg_q <= red_avg_d;
            ir_avg_q  <= ir_avg_d;
            valid_q   <= valid_d;
            primed_q  <= primed_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_red_avg = red_avg_q;
    assign out_ir_avg  = ir_avg_q;
    assign out_valid   = valid_q;
    assign out_primed  = primed_q;
    assign out_overrun = overrun_q;

endmodule

// File: tb/tb_ppg_moving_avg.sv
// Directed bench for ppg_moving_avg: window fill, step response, sign handling,
// handshake/overrun, edge detection and mid-update reset.
module tb_ppg_moving_avg;

    localparam int DW = 22;

    logic          clk = 1'b0;
    logic          in_reset = 1'b1;
    logic          in_new_samples = 1'b0;
    logic [DW-1:0] in_red = '0;
    logic [DW-1:0] in_ir = '0;
    logic [DW-1:0] out_red_avg;
    logic [DW-1:0] out_ir_avg;
    logic          out_valid;
    logic          in_ready = 1'b1;
    logic          out_primed;
    logic          out_overrun;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ppg_moving_avg #(.DATA_W(DW), .LOG2_N(3)) dut (
        .clk           (clk),
        .in_reset      (in_reset),
        .in_new_samples(in_new_samples),
        .in_red        (in_red),
        .in_ir         (in_ir),
        .out_red_avg   (out_red_avg),
        .out_ir_avg    (out_ir_avg),
        .out_valid     (out_valid),
        .in_ready      (in_ready),
        .out_primed    (out_primed),
        .out_overrun   (out_overrun)
    );

    // One sample edge, 12 clocks long; caller is at posedge+1 on entry and exit.
    task automatic sample(input int r, input int i, input logic exp_pre, input logic exp_valid,
                          input int er, input int ei, input string nm);
        in_red = DW'(r);
        in_ir = DW'(i);
        in_new_samples = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_new_samples = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== exp_pre) $display("FAIL %s pre_valid: got %b want %b", nm, out_valid, exp_pre);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== exp_valid) $display("FAIL %s valid: got %b want %b", nm, out_valid, exp_valid);
        else passed++;
        if (exp_valid) begin
            checks++;
            if (out_red_avg !== DW'(er))
                $display("FAIL %s red_avg: got %0d want %0d", nm, $signed(out_red_avg), er);
            else passed++;
            checks++;
            if (out_ir_avg !== DW'(ei))
                $display("FAIL %s ir_avg: got %0d want %0d", nm, $signed(out_ir_avg), ei);
            else passed++;
        end
        $display("sample %s: red_in=%0d ir_in=%0d valid=%b red_avg=%0d ir_avg=%0d", nm, r, i,
                 out_valid, $signed(out_red_avg), $signed(out_ir_avg));
        repeat (8) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        in_reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_primed, out_overrun} !== 3'b000)
            $display("FAIL reset flags: got %b%b%b want 000", out_valid, out_primed, out_overrun);
        else passed++;
        checks++;
        if (out_red_avg !== '0 || out_ir_avg !== '0)
            $display("FAIL reset avgs: got %0d/%0d want 0/0", out_red_avg, out_ir_avg);
        else passed++;
        $display("reset: valid=%b primed=%b overrun=%b", out_valid, out_primed, out_overrun);
    endtask

    task automatic test_fill(input string tag);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                checks++;
                if (out_primed !== 1'b0) $display("FAIL %s primed_early: got %b want 0", tag, out_primed);
                else passed++;
            end
            sample(100, -50, 1'b0, (k == 7), 100, -50, $sformatf("%s_%0d", tag, k + 1));
        end
        checks++;
        if (out_primed !== 1'b1) $display("FAIL %s primed: got %b want 1", tag, out_primed);
        else passed++;
    endtask

    task automatic test_steps();
        int red_in[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 80, 80, 80, 80, 80, 80, 80, 80};
        int red_ex[16] = '{87, 75, 62, 50, 37, 25, 12, 0, 10, 20, 30, 40, 50, 60, 70, 80};
        int ir_ex[16]  = '{-44, -38, -32, -25, -19, -13, -7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 16; k++) begin
            sample(red_in[k], 0, 1'b0, 1'b1, red_ex[k], ir_ex[k], $sformatf("step_%0d", k + 1));
        end
    endtask

    task automatic test_sign();
        int red_ex[8] = '{69, 59, 49, 39, 29, 19, 9, -1};
        for (int k = 0; k < 8; k++) begin
            int v;
            v = (k == 7) ? 0 : -1;
            sample(v, v, 1'b0, 1'b1, red_ex[k], -1, $sformatf("sign_%0d", k + 1));
        end
    endtask

    task automatic test_held_high();
        int cnt = 0;
        logic [DW-1:0] r = '0;
        logic [DW-1:0] i = '0;
        in_red = DW'(81);
        in_ir = '0;
        in_new_samples = 1'b1;
        for (int c = 0; c < 32; c++) begin
            if (c == 20) in_new_samples = 1'b0;
            @(posedge clk); #1;
            if (out_valid) begin
                cnt++;
                r = out_red_avg;
                i = out_ir_avg;
            end
        end
        checks++;
        if (cnt != 1) $display("FAIL held_high updates: got %0d want 1", cnt);
        else passed++;
        checks++;
        if (r !== DW'(9) || i !== DW'(-1))
            $display("FAIL held_high avgs: got %0d/%0d want 9/-1", $signed(r), $signed(i));
        else passed++;
        checks++;
        if (out_overrun !== 1'b0) $display("FAIL held_high overrun: got %b want 0", out_overrun);
        else passed++;
        $display("held_high: updates=%0d red_avg=%0d ir_avg=%0d", cnt, $signed(r), $signed(i));
    endtask

    task automatic test_double_edge();
        int cnt = 0;
        logic [DW-1:0] r = '0;
        logic [DW-1:0] i = '0;
        in_red = DW'(81);
        in_ir = '0;
        in_new_samples = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                cnt++;
                r = out_red_avg;
                i = out_ir_avg;
            end
            in_new_samples = (c == 1);
        end
        checks++;
        if (cnt != 1) $display("FAIL double_edge updates: got %0d want 1", cnt);
        else passed++;
        checks++;
        if (r !== DW'(19) || i !== DW'(-1))
            $display("FAIL double_edge avgs: got %0d/%0d want 19/-1", $signed(r), $signed(i));
        else passed++;
        checks++;
        if (out_overrun !== 1'b1) $display("FAIL double_edge overrun: got %b want 1", out_overrun);
        else passed++;
        $display("double_edge: updates=%0d overrun=%b red_avg=%0d", cnt, out_overrun, $signed(r));
    endtask

    task automatic test_reset_mid_update();
        in_red = DW'(81);
        in_ir = '0;
        in_new_samples = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_new_samples = 1'b0;
        in_reset = 1'b1;
        @(posedge clk); #1;
        in_reset = 1'b0;
        checks++;
        if ({out_valid, out_primed, out_overrun} !== 3'b000)
            $display("FAIL mid_reset flags: got %b%b%b want 000", out_valid, out_primed, out_overrun);
        else passed++;
        checks++;
        if (out_red_avg !== '0 || out_ir_avg !== '0)
            $display("FAIL mid_reset avgs: got %0d/%0d want 0/0", $signed(out_red_avg), $signed(out_ir_avg));
        else passed++;
        $display("mid_reset: valid=%b primed=%b overrun=%b", out_valid, out_primed, out_overrun);
        repeat (10) begin
            @(posedge clk); #1;
        end
        test_fill("refill");
    endtask

    task automatic test_overrun();
        in_ready = 1'b0;
        sample(180, -50, 1'b0, 1'b1, 110, -50, "ovr_a");
        checks++;
        if (out_overrun !== 1'b0) $display("FAIL ovr_a overrun: got %b want 0", out_overrun);
        else passed++;
        sample(180, -50, 1'b1, 1'b1, 120, -50, "ovr_b");
        checks++;
        if (out_overrun !== 1'b1) $display("FAIL ovr_b overrun: got %b want 1", out_overrun);
        else passed++;
        checks++;
        if (out_valid !== 1'b1 || out_red_avg !== DW'(120))
            $display("FAIL ovr_hold: got valid=%b red=%0d want 1/120", out_valid, $signed(out_red_avg));
        else passed++;
        in_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL ovr_accept valid: got %b want 0", out_valid);
        else passed++;
        $display("overrun: overrun=%b valid_after_accept=%b", out_overrun, out_valid);
    endtask

    initial begin
        test_reset();
        test_fill("fill");
        test_steps();
        test_sign();
        test_held_high();
        test_double_edge();
        test_reset_mid_update();
        test_overrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
